// File: rtl/fetch_hazard_controller.sv
// fetch_hazard_controller
// Front-end sequencer for a 5-stage pipeline. It generates the stall, flush and
// PC-redirect controls for the PC, IF/ID and ID/EX registers. It covers boot hold,
// instruction-memory wait states, load-use bubbles, redirects that arrive while
// fetch is stalled, and drain-and-halt. All control outputs are combinational
// from the current state and the current inputs.
module fetch_hazard_controller #(
   parameter int BOOT_CYCLES  = 4,
   parameter int DRAIN_CYCLES = 4,
   parameter int STAT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              PCSrcE,
   input  logic [31:0]       PCTargetE,
   input  logic              MemReadE,
   input  logic [4:0]        RdE,
   input  logic [4:0]        Rs1D,
   input  logic [4:0]        Rs2D,
   input  logic              ImemReadyF,
   input  logic              HaltReq,
   input  logic              ResumeReq,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic              PCSelF,
   output logic [31:0]       PCRedirectF,
   output logic              Halted,
   output logic [STAT_W-1:0] StallCount
);

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      RUN    = 3'd1,
      WAIT   = 3'd2,
      DRAIN  = 3'd3,
      HALTED = 3'd4
   } state_t;

   // One shared counter times both the boot hold and the drain, so it is
   // sized for whichever of the two is longer.
   localparam int CNT_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             pending, pending_next;
   logic [31:0]      redirect, redirect_next;
   logic             load_use;

   // Load-use hazard: the load in EX writes a register that the ID instruction
   // reads. x0 is never a real destination, so it never stalls.
   assign load_use = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

   assign PCRedirectF = redirect;

   // State, boot/drain counter, buffered redirect and pending flag.
   // NOTE: sequential state uses non-blocking (<=) so that every register samples
   // the pre-edge values, whatever order the simulator evaluates the blocks in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= BOOT;
         cnt      <= '0;
         pending  <= 1'b0;
         redirect <= '0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         pending  <= pending_next;
         redirect <= redirect_next;
      end
   end

   // Next-state logic and all control outputs.
   // NOTE: every output and next-value is given a default first. Any path that
   // leaves one of them unassigned would otherwise infer a latch.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      pending_next  = pending;
      redirect_next = redirect;
      StallF        = 1'b0;
      StallD        = 1'b0;
      FlushD        = 1'b0;
      FlushE        = 1'b0;
      PCSelF        = 1'b0;
      Halted        = 1'b0;

      unique case (state)
         BOOT: begin
            StallF = 1'b1;
            FlushD = 1'b1;
            if (cnt == BOOT_LAST) begin
               state_next = RUN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         RUN: begin
            if (pending) begin
               // First cycle after resume: steer the PC to the redirect that
               // was buffered during the drain. The word fetched from the
               // stale PC is wrong-path, so it is flushed.
               PCSelF       = 1'b1;
               FlushD       = 1'b1;
               pending_next = 1'b0;
            end else if (PCSrcE) begin
               // The ID instruction is killed, so a load-use hazard is moot.
               FlushD = 1'b1;
               FlushE = 1'b1;
            end else if (!ImemReadyF) begin
               StallF     = 1'b1;
               FlushD     = 1'b1;
               state_next = WAIT;
            end else if (load_use) begin
               StallF = 1'b1;
               StallD = 1'b1;
               FlushE = 1'b1;
            end else if (HaltReq) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end
         end

         WAIT: begin
            if (PCSrcE) begin
               FlushE        = 1'b1;
               redirect_next = PCTargetE;
            end
            if (!ImemReadyF) begin
               StallF = 1'b1;
               FlushD = 1'b1;
               if (PCSrcE) pending_next = 1'b1;
            end else begin
               state_next = RUN;
               if (PCSrcE) begin
                  // A redirect in the release cycle is newer than anything
                  // buffered. The normal mux takes PCTargetE directly.
                  FlushD       = 1'b1;
                  pending_next = 1'b0;
               end else if (pending) begin
                  PCSelF       = 1'b1;
                  FlushD       = 1'b1;
                  pending_next = 1'b0;
               end
            end
         end

         DRAIN: begin
            StallF = 1'b1;
            FlushD = 1'b1;
            if (PCSrcE) begin
               FlushE        = 1'b1;
               redirect_next = PCTargetE;
               pending_next  = 1'b1;
            end
            if (cnt == DRAIN_LAST) begin
               state_next = HALTED;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         HALTED: begin
            StallF = 1'b1;
            StallD = 1'b1;
            Halted = 1'b1;
            if (ResumeReq) state_next = RUN;
         end

         default: state_next = BOOT;
      endcase
   end

   // Saturating count of cycles lost to fetch stalls while running.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         StallCount <= '0;
      end else if (StallF && ((state == RUN) || (state == WAIT)) && (StallCount != '1)) begin
         StallCount <= StallCount + STAT_W'(1);
      end
   end

endmodule
